board_ctrl: RTL and testbench
=============================

# board_ctrl

Synchronous tic-tac-toe board controller: the receiving end of the move interface that the player input logic and the AI module drive. It samples move requests (`update_loc` plus a `submit` strobe), validates them against the current board, writes the mover's mark, evaluates win/draw, and hands the turn to the other side. It owns the authoritative `board_state` and `turn` signals that both move sources read.

## Interface
Parameters:
- `FIRST_TURN`, default 0: turn value after reset or clear. 0 = player, 1 = AI (`TURN_AI`).

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `update_loc`  input  4  cell index 0..8 of requested move, row-major (0 = top-left, 8 = bottom-right).
- `submit`  input  1  move strobe. A move is the rising edge of `submit`; the level is ignored.
- `clear`  input  1  synchronous new-game request, level-sampled.
- `board_state`  output  18  cell i occupies bits [2i+1:2i]. Encoding: 2'b00 blank (`CELL_BLANK`), 2'b01 player (X), 2'b10 AI (O).
- `turn`  output  1  whose move is accepted next: 0 = player, 1 = AI.
- `move_ack`  output  1  one-cycle pulse: move accepted and written.
- `move_err`  output  1  one-cycle pulse: move rejected.
- `game_over`  output  1  high while in OVER.
- `winner`  output  2  2'b00 none, 2'b01 player, 2'b10 AI, 2'b11 draw.

## Operation
- Edge detect: register `submit` into `submit_q`. A move edge is `submit & ~submit_q`. Holding `submit` high for any number of cycles is exactly one request.
- States:
  - WAIT: accepts moves.
  - EVAL: one cycle; checks the board just written.
  - OVER: holds the result until `clear` or `rst`.
- In WAIT, on a move edge:
  - If `update_loc` < 9 and that cell is blank: write the mark (2'b01 if `turn`=0, 2'b10 if `turn`=1), increment the 4-bit move count, pulse `move_ack`, go to EVAL.
  - Otherwise (`update_loc` ≥ 9 or cell occupied): pulse `move_err`. Board, count, turn and state are unchanged.
- EVAL checks the 8 lines: rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6.
  - A line with three equal non-blank cells: `winner` takes that cell code, `game_over`=1, go to OVER. `turn` does not toggle.
  - Else if the move count is 9: `winner`=2'b11, go to OVER.
  - Else: toggle `turn`, go to WAIT.
- Move edge in EVAL: discarded, no pulse. `submit_q` still updates, so the edge is consumed.
- Move edge in OVER: `move_err` pulse, nothing else changes.
- `clear`=1 in any state:
  - At the next edge: board all blank, count 0, `turn`=`FIRST_TURN`, `winner`=0, `game_over`=0, state WAIT.
  - `clear` has priority over a simultaneous move edge. That edge is dropped with no ack/err.
- `rst` asserted: immediately forces the same values as `clear`, plus `submit_q`=0, `move_ack`=0, `move_err`=0. If `submit` is high when `rst` releases, that counts as a new edge on the first clock.

## Timing
- Reset values: `board_state`=18'h0, `turn`=`FIRST_TURN`, `move_ack`=0, `move_err`=0, `game_over`=0, `winner`=2'b00.
- A move edge sampled at clock edge N gives:
  - At N: the cell write and the `move_ack`/`move_err` pulse, all visible after N and high for exactly one cycle.
  - At N+1: the result of EVAL. Either `turn` toggles or `game_over`/`winner` update.
- Minimum spacing between accepted moves: 2 cycles. Move sources must wait for `turn` to change before strobing.
- All outputs are registered; none is combinational from inputs.

## Test plan
- Reset, then player edges loc 4: after 1 clk `board_state[9:8]`=2'b01 and `move_ack`=1 for one cycle; after 2 clk `turn`=1.
- Occupied and out-of-range moves: after loc 4 is taken, an edge on loc 4, then an edge on loc 12 → each gives a one-cycle `move_err`; board and `turn` are unchanged.
- Held strobe: `submit` held high for 5 cycles on loc 0 → exactly one `move_ack`, move count +1.
- Win: player plays 0, 1, 2; AI plays 3, 4. One clk after the player's 2 is written, `winner`=2'b01, `game_over`=1, `turn` stays 0. A later edge gives `move_err`.
- Draw: sequence 0, 1, 2, 4, 3, 5, 7, 6, 8 → after the 9th write plus 1 clk, `winner`=2'b11, `game_over`=1.
- Clear and reset priority:
  - `clear` and a move edge in the same cycle mid-game → board 18'h0, no ack/err.
  - `rst` pulsed between clock edges → outputs go to reset values before the next edge.

Source files
------------

// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe board controller.
// Samples move requests (update_loc plus the rising edge of submit), checks
// them against the current board, writes the mover's mark and evaluates
// win/draw one cycle later. It then hands the turn to the other side.
// The board and turn registers here are the authoritative copies.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   update_loc  requested cell 0..8, row-major
//   submit      move strobe; only its rising edge counts
//   clear       synchronous new-game request (wins over a move edge)
//   board_state cell i at bits [2i+1:2i]; 00 blank, 01 player, 10 AI
//   turn        side whose move is accepted next (0 player, 1 AI)
//   move_ack    one-cycle pulse, move accepted and written
//   move_err    one-cycle pulse, move rejected
//   game_over   high while the game is finished
//   winner      00 none, 01 player, 10 AI, 11 draw
module board_ctrl #(
  parameter bit FIRST_TURN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  update_loc,
  input  logic        submit,
  input  logic        clear,
  output logic [17:0] board_state,
  output logic        turn,
  output logic        move_ack,
  output logic        move_err,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [1:0] CELL_BLANK = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  typedef enum logic [1:0] {
    WAIT,
    EVAL,
    OVER
  } state_t;

  state_t     state;
  logic       submit_q;
  logic [3:0] move_count;
  logic       move_edge;
  logic       target_blank;
  logic [1:0] win_code;
  logic [1:0] cells [9];

  function automatic logic [1:0] line_code(input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic [1:0] c);
    return (a != CELL_BLANK && a == b && b == c) ? a : CELL_BLANK;
  endfunction

  assign move_edge = submit & ~submit_q;

  // Unpack the board into cells; an out-of-range location never matches,
  // so it is never blank and falls through to the rejection path.
  always_comb begin
    target_blank = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cells[i] = board_state[2*i +: 2];
      if (update_loc == 4'(i))
        target_blank = (board_state[2*i +: 2] == CELL_BLANK);
    end
  end

  // Only the side that just moved can complete a line, so at most one mark
  // code can be present and OR-ing the eight line results is safe.
  always_comb begin
    win_code = line_code(cells[0], cells[1], cells[2])
             | line_code(cells[3], cells[4], cells[5])
             | line_code(cells[6], cells[7], cells[8])
             | line_code(cells[0], cells[3], cells[6])
             | line_code(cells[1], cells[4], cells[7])
             | line_code(cells[2], cells[5], cells[8])
             | line_code(cells[0], cells[4], cells[8])
             | line_code(cells[2], cells[4], cells[6]);
  end

  // Main game FSM with registered outputs. submit_q always follows submit
  // (outside reset), so an edge that arrives in EVAL or alongside clear
  // is consumed even though it has no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT;
      submit_q    <= 1'b0;
      move_count  <= 4'd0;
      board_state <= 18'h0;
      turn        <= FIRST_TURN;
      move_ack    <= 1'b0;
      move_err    <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      submit_q <= submit;
      move_ack <= 1'b0;
      move_err <= 1'b0;
      if (clear) begin
        state       <= WAIT;
        move_count  <= 4'd0;
        board_state <= 18'h0;
        turn        <= FIRST_TURN;
        game_over   <= 1'b0;
        winner      <= 2'b00;
      end else begin
        case (state)
          WAIT: begin
            if (move_edge) begin
              if (target_blank) begin
                for (int i = 0; i < 9; i++) begin
                  if (update_loc == 4'(i))
                    board_state[2*i +: 2] <= turn ? CELL_O : CELL_X;
                end
                move_count <= move_count + 4'd1;
                move_ack   <= 1'b1;
                state      <= EVAL;
              end else begin
                move_err <= 1'b1;
              end
            end
          end
          EVAL: begin
            if (win_code != CELL_BLANK) begin
              winner    <= win_code;
              game_over <= 1'b1;
              state     <= OVER;
            end else if (move_count == 4'd9) begin
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              turn  <= ~turn;
              state <= WAIT;
            end
          end
          OVER: begin
            if (move_edge)
              move_err <= 1'b1;
          end
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: self-checking bench for board_ctrl.
// A small game model predicts each ack/err pulse together with the board
// that should accompany it. The prediction is queued when the move edge is
// driven, and a monitor pops and compares it when the DUT pulses.
module tb_board_ctrl;

  localparam bit FIRST = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  update_loc;
  logic        submit;
  logic        clear;
  logic [17:0] board_state;
  logic        turn;
  logic        move_ack;
  logic        move_err;
  logic        game_over;
  logic [1:0]  winner;

  board_ctrl #(.FIRST_TURN(FIRST)) dut (
    .clk        (clk),
    .rst        (rst),
    .update_loc (update_loc),
    .submit     (submit),
    .clear      (clear),
    .board_state(board_state),
    .turn       (turn),
    .move_ack   (move_ack),
    .move_err   (move_err),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_ack;
    logic [17:0] board;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  logic [1:0] mb [9];
  logic       mturn;
  logic [3:0] mcount;
  logic       mover;
  logic [1:0] mwin;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [17:0] packBoard();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = mb[i];
    return b;
  endfunction

  function automatic logic [1:0] modelWinner();
    int lines [8][3];
    lines = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int l = 0; l < 8; l++) begin
      if (mb[lines[l][0]] != 2'b00 && mb[lines[l][0]] == mb[lines[l][1]]
          && mb[lines[l][1]] == mb[lines[l][2]])
        return mb[lines[l][0]];
    end
    return 2'b00;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 9; i++) mb[i] = 2'b00;
    mturn  = FIRST;
    mcount = 4'd0;
    mover  = 1'b0;
    mwin   = 2'b00;
  endtask

  // Predict the outcome of one move edge and queue the expected pulse.
  task automatic modelMove(input logic [3:0] loc);
    if (mover || loc >= 4'd9) begin
      expq.push_back('{1'b0, packBoard()});
    end else if (mb[loc] != 2'b00) begin
      expq.push_back('{1'b0, packBoard()});
    end else begin
      mb[loc] = mturn ? 2'b10 : 2'b01;
      mcount++;
      expq.push_back('{1'b1, packBoard()});
      mwin = modelWinner();
      if (mwin != 2'b00) mover = 1'b1;
      else if (mcount == 4'd9) begin
        mwin  = 2'b11;
        mover = 1'b1;
      end else mturn = ~mturn;
    end
  endtask

  // Monitor: every pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (move_ack || move_err) begin
      checkOutput("pulse_exclusive", {31'd0, move_ack & move_err}, 32'd0);
      if (expq.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, move_ack, move_err}, 32'd0);
      end else begin
        e = expq.pop_front();
        checkOutput("pulse_kind", {31'd0, move_ack}, {31'd0, e.is_ack});
        checkOutput("pulse_board", {14'd0, board_state}, {14'd0, e.board});
      end
    end
  end

  task automatic checkState(input string tag);
    checkOutput({tag, "_board"}, {14'd0, board_state}, {14'd0, packBoard()});
    checkOutput({tag, "_turn"}, {31'd0, turn}, {31'd0, mturn});
    checkOutput({tag, "_over"}, {31'd0, game_over}, {31'd0, mover});
    checkOutput({tag, "_winner"}, {30'd0, winner}, {30'd0, mwin});
    checkOutput({tag, "_pending"}, expq.size(), 32'd0);
  endtask

  // Drive one move edge, hold submit for 'hold' cycles, then let EVAL finish.
  task automatic applyStimulus(input logic [3:0] loc, input int hold,
                               input string tag);
    @(negedge clk);
    update_loc = loc;
    submit     = 1'b1;
    modelMove(loc);
    repeat (hold) @(negedge clk);
    submit = 1'b0;
    repeat (2) @(negedge clk);
    checkState(tag);
  endtask

  task automatic doClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    modelReset();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] draw_seq [9];
    draw_seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

    rst        = 1'b1;
    submit     = 1'b0;
    clear      = 1'b0;
    update_loc = 4'd0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ack", {31'd0, move_ack}, 32'd0);
    checkOutput("reset_err", {31'd0, move_err}, 32'd0);
    checkState("reset");

    // First move, then occupied and out-of-range attempts by the AI.
    applyStimulus(4'd4, 1, "first_move");
    applyStimulus(4'd4, 1, "occupied");
    applyStimulus(4'd12, 1, "out_of_range");

    // Held strobe: five cycles high is a single move.
    applyStimulus(4'd0, 5, "held");

    // clear together with a legal move edge: board wiped, no pulse.
    @(negedge clk);
    clear      = 1'b1;
    update_loc = 4'd8;
    submit     = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    submit = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkState("clear_prio");

    // Player wins on the top row; a later edge is rejected.
    applyStimulus(4'd0, 1, "win_p0");
    applyStimulus(4'd3, 1, "win_a3");
    applyStimulus(4'd1, 1, "win_p1");
    applyStimulus(4'd4, 1, "win_a4");
    applyStimulus(4'd2, 1, "win_p2");
    applyStimulus(4'd8, 1, "after_win");

    // Asynchronous reset between clock edges, with submit high on release.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_rst_board", {14'd0, board_state}, 32'd0);
    checkOutput("async_rst_over", {31'd0, game_over}, 32'd0);
    checkOutput("async_rst_winner", {30'd0, winner}, 32'd0);
    checkOutput("async_rst_turn", {31'd0, turn}, {31'd0, FIRST});
    update_loc = 4'd5;
    submit     = 1'b1;
    modelMove(4'd5);
    #1 rst = 1'b0;
    @(negedge clk);
    submit = 1'b0;
    repeat (2) @(negedge clk);
    checkState("rst_edge");

    // Full draw game.
    doClear();
    checkState("pre_draw");
    for (int i = 0; i < 9; i++) applyStimulus(draw_seq[i], 1, "draw");

    repeat (3) @(negedge clk);
    checkOutput("final_pending", expq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
